// File: rtl/renesas_gpio_ctrl.sv
// renesas_gpio_ctrl
// Register-mapped GPIO and RSTN controller for up to four jitter-cleaner
// devices. Each device owns a GPIO_W-bit pin group with direction and drive
// registers. The RSTN pin can be forced low for a programmable number of
// cycles.
//
// Optional feature macro: RENESAS_GPIO_IRQ_EN
//   When defined, per-pin edge detection, rise/fall enables, sticky W1C
//   status and the irq output are built.
//   When undefined, none of those flops exist: the enable and status
//   registers read 0 and ignore writes, and irq is tied low.

module renesas_gpio_ctrl #(
  parameter int NUM_DEV  = 2,
  parameter int GPIO_W   = 6,
  parameter int PULSE_CW = 16
) (
  input  logic                        sys_if_clk,
  input  logic                        sys_if_rstn,
  input  logic                        sys_if_wen,
  input  logic [31:0]                 sys_if_addr,
  input  logic [31:0]                 sys_if_wdata,
  output logic [31:0]                 sys_if_rdata,
  input  logic [127:0]                IO_HEADER_VALUE,
  input  logic                        IO_JITT_RSTN_IN_VALUE,
  output logic                        IO_JITT_RSTN_OUT_VALUE,
  output logic                        IO_JITT_RSTN_CFG_VALUE,
  input  logic [NUM_DEV*GPIO_W-1:0]   IO_GPIO_IN_VALUE,
  output logic [NUM_DEV*GPIO_W-1:0]   IO_GPIO_OUT_VALUE,
  output logic [NUM_DEV*GPIO_W-1:0]   IO_GPIO_CFG_VALUE,
  output logic                        irq
);

  localparam int BUS_W = NUM_DEV * GPIO_W;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Register offsets inside the global block and inside each device slot.
  localparam logic [4:0] OFF_HDR0     = 5'h00;
  localparam logic [4:0] OFF_HDR1     = 5'h04;
  localparam logic [4:0] OFF_HDR2     = 5'h08;
  localparam logic [4:0] OFF_HDR3     = 5'h0C;
  localparam logic [4:0] OFF_RSTN_IN  = 5'h10;
  localparam logic [4:0] OFF_RSTN_OUT = 5'h14;
  localparam logic [4:0] OFF_RSTN_CFG = 5'h18;
  localparam logic [4:0] OFF_PULSE    = 5'h1C;

  localparam logic [4:0] OFF_DEV_IN   = 5'h00;
  localparam logic [4:0] OFF_DEV_OUT  = 5'h04;
  localparam logic [4:0] OFF_DEV_CFG  = 5'h08;
`ifdef RENESAS_GPIO_IRQ_EN
  localparam logic [4:0] OFF_DEV_ERIS = 5'h0C;
  localparam logic [4:0] OFF_DEV_EFAL = 5'h10;
  localparam logic [4:0] OFF_DEV_STAT = 5'h14;
`endif

  // Only the low bits of wdata are stored; the rest are deliberately dropped.
  logic unusedWdata;
  assign unusedWdata = ^sys_if_wdata;

  // --------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------
  logic               globalSel;
  logic [NUM_DEV-1:0] devSel;
  logic [4:0]         regOff;

  assign regOff    = sys_if_addr[4:0];
  assign globalSel = (sys_if_addr[31:5] == 27'd0);

  // Slot d lives at (d+1)*0x20; slots beyond NUM_DEV simply never match.
  always_comb begin
    devSel = '0;
    for (int d = 0; d < NUM_DEV; d++) begin
      devSel[d] = (sys_if_addr[31:5] == 27'(d + 1));
    end
  end

  logic wrRstnOut;
  logic wrRstnCfg;
  logic wrPulse;

  assign wrRstnOut = sys_if_wen & globalSel & (regOff == OFF_RSTN_OUT);
  assign wrRstnCfg = sys_if_wen & globalSel & (regOff == OFF_RSTN_CFG);
  assign wrPulse   = sys_if_wen & globalSel & (regOff == OFF_PULSE);

  logic [NUM_DEV-1:0] wrOut;
  logic [NUM_DEV-1:0] wrCfg;

  // Per-device write strobes for the direction and drive registers.
  always_comb begin
    wrOut = '0;
    wrCfg = '0;
    for (int d = 0; d < NUM_DEV; d++) begin
      wrOut[d] = sys_if_wen & devSel[d] & (regOff == OFF_DEV_OUT);
      wrCfg[d] = sys_if_wen & devSel[d] & (regOff == OFF_DEV_CFG);
    end
  end

  // --------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------
  logic             rstnMeta_q;
  logic             rstnSync_q;
  logic [BUS_W-1:0] gpioMeta_q;
  logic [BUS_W-1:0] gpioSync_q;

  // Two-flop synchronisers for the asynchronous RSTN and GPIO pins.
  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      rstnMeta_q <= 1'b0;
      rstnSync_q <= 1'b0;
      gpioMeta_q <= '0;
      gpioSync_q <= '0;
    end else begin
      rstnMeta_q <= IO_JITT_RSTN_IN_VALUE;
      rstnSync_q <= rstnMeta_q;
      gpioMeta_q <= IO_GPIO_IN_VALUE;
      gpioSync_q <= gpioMeta_q;
    end
  end

  // --------------------------------------------------------------------
  // Global RSTN registers
  // --------------------------------------------------------------------
  logic rstnOut_q;
  logic rstnCfg_q;

  // Stored RSTN drive/direction; still writable while a pulse runs.
  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      rstnOut_q <= 1'b0;
      rstnCfg_q <= 1'b1;
    end else begin
      if (wrRstnOut) rstnOut_q <= sys_if_wdata[0];
      if (wrRstnCfg) rstnCfg_q <= sys_if_wdata[0];
    end
  end

  // --------------------------------------------------------------------
  // RSTN pulse generator
  // --------------------------------------------------------------------
  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic [PULSE_CW-1:0] cnt_q;
  logic [PULSE_CW-1:0] cnt_d;
  logic                busy;

  assign busy = (state_q == ST_BUSY);

  // Start on a non-zero write while idle; count down and leave BUSY as the
  // counter hits zero, which holds RSTN low for exactly N cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (wrPulse && (sys_if_wdata[PULSE_CW-1:0] != '0)) begin
        state_d = ST_BUSY;
        cnt_d   = sys_if_wdata[PULSE_CW-1:0];
      end
    end else begin
      cnt_d = cnt_q - PULSE_CW'(1);
      if (cnt_q == PULSE_CW'(1)) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Pulse state register; reset aborts any pulse in flight.
  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IO_JITT_RSTN_OUT_VALUE = rstnOut_q & ~busy;
  assign IO_JITT_RSTN_CFG_VALUE = rstnCfg_q & ~busy;

  // --------------------------------------------------------------------
  // Per-device GPIO drive and direction
  // --------------------------------------------------------------------
  logic [NUM_DEV-1:0][GPIO_W-1:0] gpioOut_q;
  logic [NUM_DEV-1:0][GPIO_W-1:0] gpioCfg_q;

  // GPIO drive values and tristate controls; pins come up as inputs.
  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      gpioOut_q <= '0;
      gpioCfg_q <= '1;
    end else begin
      for (int d = 0; d < NUM_DEV; d++) begin
        if (wrOut[d]) gpioOut_q[d] <= sys_if_wdata[GPIO_W-1:0];
        if (wrCfg[d]) gpioCfg_q[d] <= sys_if_wdata[GPIO_W-1:0];
      end
    end
  end

  assign IO_GPIO_OUT_VALUE = gpioOut_q;
  assign IO_GPIO_CFG_VALUE = gpioCfg_q;

  // --------------------------------------------------------------------
  // Edge-triggered interrupt logic
  // --------------------------------------------------------------------
`ifdef RENESAS_GPIO_IRQ_EN
  logic [BUS_W-1:0]               gpioDly_q;
  logic [1:0]                     fill_q;
  logic                           filled;
  logic [BUS_W-1:0]               riseEv;
  logic [BUS_W-1:0]               fallEv;
  logic [NUM_DEV-1:0][GPIO_W-1:0] irqEnRise_q;
  logic [NUM_DEV-1:0][GPIO_W-1:0] irqEnFall_q;
  logic [NUM_DEV-1:0][GPIO_W-1:0] irqStat_q;
  logic [NUM_DEV-1:0][GPIO_W-1:0] irqStat_d;
  logic [NUM_DEV-1:0]             wrEnRise;
  logic [NUM_DEV-1:0]             wrEnFall;
  logic [NUM_DEV-1:0]             wrStat;

  assign filled = (fill_q == 2'd2);
  assign riseEv = filled ? (gpioSync_q & ~gpioDly_q) : '0;
  assign fallEv = filled ? (~gpioSync_q & gpioDly_q) : '0;

  // Write strobes for the interrupt enable and status registers.
  always_comb begin
    wrEnRise = '0;
    wrEnFall = '0;
    wrStat   = '0;
    for (int d = 0; d < NUM_DEV; d++) begin
      wrEnRise[d] = sys_if_wen & devSel[d] & (regOff == OFF_DEV_ERIS);
      wrEnFall[d] = sys_if_wen & devSel[d] & (regOff == OFF_DEV_EFAL);
      wrStat[d]   = sys_if_wen & devSel[d] & (regOff == OFF_DEV_STAT);
    end
  end

  // Until the synchroniser has filled after reset, the delay flop tracks
  // the value stage 2 is about to take, so a pin already high is no edge.
  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      fill_q    <= 2'd0;
      gpioDly_q <= '0;
    end else begin
      if (!filled) fill_q <= fill_q + 2'd1;
      gpioDly_q <= filled ? gpioSync_q : gpioMeta_q;
    end
  end

  // Sticky status: W1C clears, but a qualifying edge in the same cycle wins.
  always_comb begin
    irqStat_d = irqStat_q;
    for (int d = 0; d < NUM_DEV; d++) begin
      irqStat_d[d] = (irqStat_q[d] & ~(wrStat[d] ? sys_if_wdata[GPIO_W-1:0] : '0))
                   | (riseEv[d*GPIO_W +: GPIO_W] & irqEnRise_q[d])
                   | (fallEv[d*GPIO_W +: GPIO_W] & irqEnFall_q[d]);
    end
  end

  // Enable and status registers; changing an enable leaves status alone.
  always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
    if (!sys_if_rstn) begin
      irqEnRise_q <= '0;
      irqEnFall_q <= '0;
      irqStat_q   <= '0;
    end else begin
      irqStat_q <= irqStat_d;
      for (int d = 0; d < NUM_DEV; d++) begin
        if (wrEnRise[d]) irqEnRise_q[d] <= sys_if_wdata[GPIO_W-1:0];
        if (wrEnFall[d]) irqEnFall_q[d] <= sys_if_wdata[GPIO_W-1:0];
      end
    end
  end

  assign irq = |irqStat_q;
`else
  assign irq = 1'b0;
`endif

  // --------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------
  // Zero-latency read path; anything not decoded returns 0.
  always_comb begin
    sys_if_rdata = '0;
    if (globalSel) begin
      case (regOff)
        OFF_HDR0:     sys_if_rdata = IO_HEADER_VALUE[31:0];
        OFF_HDR1:     sys_if_rdata = IO_HEADER_VALUE[63:32];
        OFF_HDR2:     sys_if_rdata = IO_HEADER_VALUE[95:64];
        OFF_HDR3:     sys_if_rdata = IO_HEADER_VALUE[127:96];
        OFF_RSTN_IN:  sys_if_rdata = 32'(rstnSync_q);
        OFF_RSTN_OUT: sys_if_rdata = 32'(rstnOut_q);
        OFF_RSTN_CFG: sys_if_rdata = 32'(rstnCfg_q);
        OFF_PULSE: begin
          sys_if_rdata     = 32'(cnt_q);
          sys_if_rdata[31] = busy;
        end
        default:      sys_if_rdata = '0;
      endcase
    end
    for (int d = 0; d < NUM_DEV; d++) begin
      if (devSel[d]) begin
        case (regOff)
          OFF_DEV_IN:   sys_if_rdata = 32'(gpioSync_q[d*GPIO_W +: GPIO_W]);
          OFF_DEV_OUT:  sys_if_rdata = 32'(gpioOut_q[d]);
          OFF_DEV_CFG:  sys_if_rdata = 32'(gpioCfg_q[d]);
`ifdef RENESAS_GPIO_IRQ_EN
          OFF_DEV_ERIS: sys_if_rdata = 32'(irqEnRise_q[d]);
          OFF_DEV_EFAL: sys_if_rdata = 32'(irqEnFall_q[d]);
          OFF_DEV_STAT: sys_if_rdata = 32'(irqStat_q[d]);
`endif
          default:      sys_if_rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: doc/renesas_gpio_ctrl.md
RENESAS_GPIO_CTRL -- requirements
Module: renesas_gpio_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_DEV, 2, number of jitter-cleaner devices, range 1..4.
- GPIO_W, 6, GPIO pins per device, range 1..16.
- PULSE_CW, 16, width of the reset-pulse counter.
REQ-002 Ports (name, direction, width, meaning), one per line:
- sys_if_clk, in, 1, sole clock.
- sys_if_rstn, in, 1, asynchronous active-low reset.
- sys_if_wen, in, 1, write strobe.
- sys_if_addr, in, 32, byte address.
- sys_if_wdata, in, 32, write data.
- sys_if_rdata, out, 32, combinational read data.
- IO_HEADER_VALUE, in, 128, four 32-bit read-only header words; word n is bits [32n+31:32n].
- IO_JITT_RSTN_IN_VALUE, in, 1, raw RSTN pin.
- IO_JITT_RSTN_OUT_VALUE, out, 1, RSTN drive value.
- IO_JITT_RSTN_CFG_VALUE, out, 1, RSTN tristate (1 = input).
- IO_GPIO_IN_VALUE, in, NUM_DEV*GPIO_W, raw, asynchronous GPIO pins.
- IO_GPIO_OUT_VALUE, out, NUM_DEV*GPIO_W, GPIO drive values.
- IO_GPIO_CFG_VALUE, out, NUM_DEV*GPIO_W, GPIO tristate (1 = input).
- irq, out, 1, level interrupt.
REQ-003 Device d SHALL occupy bits [d*GPIO_W+GPIO_W-1 : d*GPIO_W] of every per-device bus.

Function
REQ-004 Global register map SHALL be as follows; unlisted bits read 0:
- 0x00/0x04/0x08/0x0C: HEADER0-3, RO.
- 0x10: RSTN_IN, RO, synchronised.
- 0x14: RSTN_OUT, RW.
- 0x18: RSTN_CFG, RW.
- 0x1C: RSTN_PULSE. Write starts a pulse. Read: bit31 = busy, [PULSE_CW-1:0] = remaining count.
REQ-005 Device d base SHALL be 0x20+0x20*d, with registers at these offsets, each GPIO_W bits wide:
- +0x00 IN, RO, synchronised.
- +0x04 OUT, RW.
- +0x08 CFG, RW.
- +0x0C IRQ_EN_RISE, RW.
- +0x10 IRQ_EN_FALL, RW.
- +0x14 IRQ_STAT, W1C.
REQ-006 Unmapped addresses, and device slots at or above NUM_DEV, SHALL read 0 and ignore writes.
REQ-007 A write SHALL take effect on the sys_if_clk edge where sys_if_wen=1 and the address matches; wdata bits above the register width are ignored.
REQ-008 Every GPIO and RSTN input SHALL pass a 2-flop synchroniser.
- A pin level sampled at edge k is readable via IN after edge k+1.
REQ-009 Edge detection SHALL compare synchroniser stage 2 against a third delay flop.
- A rise/fall sampled at edge k sets IRQ_STAT[i] at edge k+2, if the matching IRQ_EN_RISE[i]/IRQ_EN_FALL[i] bit is 1.
REQ-010 IRQ_STAT bits SHALL be sticky until cleared by writing 1; writing 0 has no effect.
REQ-011 If a W1C clear and a new qualifying edge hit the same bit in the same cycle, set SHALL win.
REQ-012 irq SHALL be the combinational OR of all IRQ_STAT bits, across all devices.
REQ-013 Clearing an enable bit SHALL NOT clear an already-set status bit.
REQ-014 Pulse generator states SHALL be IDLE and BUSY.
- Write N≠0 to 0x1C while IDLE: load counter with N, go BUSY at that edge.
- BUSY: decrement each cycle; return to IDLE on the edge where the counter reaches 0.
REQ-015 The RSTN output is forced low for exactly N cycles per pulse.
- Writing N=0 while IDLE SHALL be ignored.
- Writing 0x1C while BUSY SHALL be ignored; no restart.
REQ-016 IO_JITT_RSTN_OUT_VALUE SHALL equal RSTN_OUT & ~busy.
- IO_JITT_RSTN_CFG_VALUE SHALL be forced to 0 while busy, i.e. driven.
- The stored RSTN_OUT/RSTN_CFG values are still writable during BUSY and take effect afterwards.
REQ-017 sys_if_rdata SHALL be purely combinational from sys_if_addr and register state, with zero-cycle latency.

Reset
REQ-018 On sys_if_rstn=0, asynchronously:
- RSTN_OUT=0, RSTN_CFG=1.
- All GPIO OUT=0, all GPIO CFG=all ones.
- All IRQ_EN and IRQ_STAT=0.
- Synchroniser and delay flops=0.
- Pulse state IDLE, counter 0.
- Resulting outputs: irq=0, IO_JITT_RSTN_OUT_VALUE=0, IO_JITT_RSTN_CFG_VALUE=1.
REQ-019 Reset asserted mid-pulse SHALL abort the pulse.
REQ-020 No edge SHALL be reported on the first cycles after reset release solely because a pin is already high.
- Implementation: the delay flop is loaded equal to stage 2 until the synchroniser has filled, 2 cycles after release.

Configuration
REQ-021 Macro RENESAS_GPIO_IRQ_EN:
- Defined: REQ-009 to REQ-013 are implemented.
- Undefined: no edge-detect, enable or status flops exist. IRQ_EN_*/IRQ_STAT read 0 and ignore writes; irq is tied to 0. All other behaviour is unchanged.

Verification
REQ-022 Reset release, then read 0x18, 0x28, 0x48 -> 0x1, 0x3F, 0x3F (NUM_DEV=2, GPIO_W=6); irq=0.
REQ-023 Write 0x1C=5 -> RSTN_OUT low for exactly 5 cycles and 0x1C bit31=1 during that time; a second write of 9 mid-pulse is ignored; after the pulse, output returns to RSTN_OUT.
REQ-024 IRQ_EN_RISE dev1=0x01, drive pin 1.0 high at edge k -> IRQ_STAT 0x54 = 0x01 at edge k+2 and irq=1; write 0x54=0x01 -> irq=0.
REQ-025 W1C of 0x34 bit 2 in the same cycle as a new qualifying fall on pin 0.2 -> bit stays 1.
REQ-026 Assert sys_if_rstn mid-pulse (count 3 remaining) -> IO_JITT_RSTN_OUT_VALUE=0, CFG=1 immediately; after release, pulse IDLE.
REQ-027 Build without RENESAS_GPIO_IRQ_EN and toggle all pins -> irq stays 0 and 0x34 reads 0.
